alu_flag_stage: RTL

// - Registered stage directly downstream of the add/subtract unit.
// - Captures result, carry-out and overflow; derives N and Z; holds the architectural NZCV flags.
// - Feeds flag C back as the add/subtract carry-in, so ADC/SBC chain correctly.
// - Forwards result/destination to writeback through a 2-entry skid buffer with valid/ready backpressure.

---
 rtl/eep_pkg.sv | 37 +++
 rtl/alu_flag_stage_skid_buffer.sv | 69 ++++++
 rtl/alu_flag_stage.sv | 73 +++++++
 3 files changed

// File: rtl/eep_pkg.sv
// Shared types and constants for the execute stage: flag layout, datapath
// widths and the writeback beat carried through the skid buffer.
package eep_pkg;

  localparam int REG_WIDTH  = 16;
  localparam int REG_ADDR_W = 3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic [REG_WIDTH-1:0]  result;
    logic                  wen;
    logic [REG_ADDR_W-1:0] dest;
  } wb_beat_t;

  function automatic flags_t derive_flags(input logic [REG_WIDTH-1:0] result,
                                          input logic carry,
                                          input logic ovf);
    flags_t f;
    f.n = result[REG_WIDTH-1];
    f.z = (result == '0);
    f.c = carry;
    f.v = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_flag_stage_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer. in_ready is registered so there is
// no combinational path from out_ready back to the producer.
module skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  T     main_q, main_d;
  T     skid_q, skid_d;
  logic acc, emit;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

  assign acc  = in_valid & in_ready;
  assign emit = main_valid_q & out_ready;

  // An accept never coincides with a valid skid entry, since in_ready is low then.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (emit) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        main_d = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (acc) begin
      if (!main_valid_q) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_data;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered stage after the add/subtract unit: holds NZCV, feeds C back as
// carry-in, and forwards results to writeback through a skid buffer.
module alu_flag_stage
  import eep_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_WIDTH-1:0]  in_result,
  input  logic                  in_carry,
  input  logic                  in_flagv,
  input  logic                  in_setflags,
  input  logic                  in_wen,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  flags_we,
  input  logic [3:0]            flags_wdata,
  output logic [3:0]            flags,
  output logic                  alu_carryin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_WIDTH-1:0]  out_result,
  output logic                  out_wen,
  output logic [REG_ADDR_W-1:0] out_dest
);

  flags_t   flags_q, flags_d;
  wb_beat_t in_beat, out_beat;
  logic     acc;

  assign in_beat.result = in_result;
  assign in_beat.wen    = in_wen;
  assign in_beat.dest   = in_dest;

  skid_buffer #(.T(wb_beat_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_beat)
  );

  assign out_result = out_beat.result;
  assign out_wen    = out_beat.wen;
  assign out_dest   = out_beat.dest;

  assign acc = in_valid & in_ready;

  // Flags track acceptance, not writeback; a flag-move write overrides the ALU.
  always_comb begin
    flags_d = flags_q;
    if (flags_we) begin
      flags_d = flags_t'(flags_wdata);
    end else if (acc && in_setflags) begin
      flags_d = derive_flags(in_result, in_carry, in_flagv);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags       = flags_q;
  assign alu_carryin = flags[FLAG_C];

endmodule
